// File: rtl/player_input_conditioner.sv
// player_input_conditioner: conditions the six raw player buttons before game_logic.
// Bit order of btn_raw_i, btn_level_o and btn_press_o:
//   [0]left [1]right [2]up [3]down [4]chop [5]carry
// Each button passes through its own lane (player_btn_lane). A lane has a 2-FF
// synchroniser, a counter debounce that drives the debounced level, and a
// registered one-cycle press pulse gated by enable_i.
// Optional feature macro: PLAYER_AUTO_REPEAT_EN. When it is defined, direction
// lanes [3:0] re-pulse while held: first after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles. When it is undefined, no repeat hardware exists and
// each press gives exactly one pulse.

module player_btn_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 40_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int RPT_W           = 26,
  parameter bit RPT_EN          = 1'b0
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic raw_i,
  input  logic enable_i,
  output logic level_o,
  output logic press_o
);
  localparam logic [CNT_W-1:0] CNT_TERM     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DLY_TERM = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_TERM = RPT_W'(REPEAT_PERIOD - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rise;
  logic             rpt_fire;

  // Debounce: count while the synced input disagrees with the level; flip at terminal count.
  // Any return to agreement before terminal count clears the counter.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise    = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TERM) begin
      level_d = s2_q;
      cnt_d   = '0;
      rise    = s2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Press pulse only on a rising flip (or a repeat), and only when enabled at that edge.
  always_comb begin
    press_d = (rise | rpt_fire) & enable_i;
  end

  // Synchroniser, debounce state and the registered pulse.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

`ifdef PLAYER_AUTO_REPEAT_EN
  if (RPT_EN) begin : g_rpt
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_arm_q, rpt_arm_d;  // 1 once the first (delay) repeat has fired
    logic             rpt_hit;

    // Repeat timer: idle while released (which also covers the press pulse cycle,
    // since level is still 0 then), held at 0 while disabled, else counts to the
    // delay terminal first and then the period terminal.
    always_comb begin
      rpt_cnt_d = rpt_cnt_q;
      rpt_arm_d = rpt_arm_q;
      rpt_hit   = 1'b0;
      if (!level_q) begin
        rpt_cnt_d = '0;
        rpt_arm_d = 1'b0;
      end else if (!enable_i) begin
        rpt_cnt_d = '0;
      end else if (rpt_cnt_q == (rpt_arm_q ? RPT_PER_TERM : RPT_DLY_TERM)) begin
        rpt_hit   = 1'b1;
        rpt_cnt_d = '0;
        rpt_arm_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end

    assign rpt_fire = rpt_hit;

    // Repeat timer state.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        rpt_cnt_q <= '0;
        rpt_arm_q <= 1'b0;
      end else begin
        rpt_cnt_q <= rpt_cnt_d;
        rpt_arm_q <= rpt_arm_d;
      end
    end
  end else begin : g_no_rpt
    logic [RPT_W-1:0] unused_rpt_cfg;
    assign unused_rpt_cfg = RPT_DLY_TERM ^ RPT_PER_TERM;
    assign rpt_fire       = 1'b0;
  end
`else
  logic [RPT_W:0] unused_rpt_cfg;
  assign unused_rpt_cfg = {RPT_EN, RPT_DLY_TERM ^ RPT_PER_TERM};
  assign rpt_fire       = 1'b0;
`endif

  assign level_o = level_q;
  assign press_o = press_q;
endmodule

module player_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 40_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int RPT_W           = 26
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic [5:0] btn_raw_i,
  input  logic       enable_i,
  output logic [5:0] btn_level_o,
  output logic [5:0] btn_press_o,
  output logic       any_press_o
);
  localparam int             NUM_BTNS = 6;
  // Only the direction buttons may auto-repeat; chop and carry never do.
  localparam logic [NUM_BTNS-1:0] RPT_MASK = 6'b00_1111;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_lane
    player_btn_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .RPT_W           (RPT_W),
      .RPT_EN          (RPT_MASK[i])
    ) u_lane (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .raw_i     (btn_raw_i[i]),
      .enable_i  (enable_i),
      .level_o   (btn_level_o[i]),
      .press_o   (btn_press_o[i])
    );
  end

  // Pulses are already registered per lane, so the OR lands in the same cycle.
  assign any_press_o = |btn_press_o;
endmodule
